// File: rtl/hdmipktrx.sv
// HDMI data-island packet receiver: de-interleaves 32 beats, checks header/subpacket BCH ECC,
// and replays the 31 packet bytes as a byte stream with per-packet error flags.
module hdmipktrx #(
  parameter bit OPT_DROP_BAD = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       S_VALID,
  output logic       S_READY,
  input  logic       S_HDR,
  input  logic [7:0] S_DATA,
  input  logic       S_LAST,
  output logic       M_VALID,
  input  logic       M_READY,
  output logic [7:0] M_DATA,
  output logic       M_LAST,
  output logic [4:0] M_ERR,
  output logic       o_frame_err
);

  typedef enum logic [1:0] {ST_RX, ST_OUT, ST_SYNC} state_t;

  function automatic logic [7:0] ecc_step(input logic [7:0] f, input logic b);
    ecc_step = (b ^ f[7]) ? ({f[6:0], 1'b0} ^ 8'hC1) : {f[6:0], 1'b0};
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [4:0]  ocnt_q;
  logic [23:0] hdr_q;
  logic [7:0]  rhecc_q, hecc_q;
  logic [7:0]  e_q [4];
  logic [7:0]  r_q [4];
  logic [7:0]  pb_q [28];
  logic [4:0]  err_q;
  logic        ferr_q, ferr_d;

  logic        accept, out_hs;
  logic [7:0]  hecc_nx, rhecc_fin;
  logic [7:0]  e_nx [4];
  logic [7:0]  r_fin [4];
  logic [4:0]  err_nx;

  assign accept = S_VALID && S_READY;
  assign out_hs = M_VALID && M_READY;

  // Accumulators restart from zero on beat 0, so aborted packets need no explicit clear.
  always_comb begin
    hecc_nx   = ecc_step((cnt_q == 6'd0) ? 8'h00 : hecc_q, S_HDR);
    rhecc_fin = {rhecc_q[6:0], S_HDR};
    err_nx    = 5'd0;
    err_nx[4] = (hecc_q != rhecc_fin);
    for (int k = 0; k < 4; k++) begin
      e_nx[k]   = ecc_step(ecc_step((cnt_q == 6'd0) ? 8'h00 : e_q[k], S_DATA[k]), S_DATA[k+4]);
      r_fin[k]  = {r_q[k][5:0], S_DATA[k], S_DATA[k+4]};
      err_nx[k] = (e_q[k] != r_fin[k]);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_RX;
      cnt_q   <= 6'd0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ferr_d  = 1'b0;
    case (state_q)
      ST_RX: begin
        if (accept) begin
          if (cnt_q == 6'd31) begin
            cnt_d = 6'd0;
            if (!S_LAST) begin
              ferr_d  = 1'b1;
              state_d = ST_SYNC;
            end else if (!(OPT_DROP_BAD && (err_nx != 5'd0))) begin
              state_d = ST_OUT;
            end
          end else if (S_LAST) begin
            ferr_d = 1'b1;
            cnt_d  = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      ST_OUT: begin
        if (out_hs && (ocnt_q == 5'd30)) state_d = ST_RX;
      end
      ST_SYNC: begin
        cnt_d = 6'd0;
        if (accept && S_LAST) state_d = ST_RX;
      end
      default: state_d = ST_RX;
    endcase
  end

  always_comb begin
    S_READY     = (state_q != ST_OUT);
    M_VALID     = (state_q == ST_OUT);
    M_LAST      = (state_q == ST_OUT) && (ocnt_q == 5'd30);
    M_ERR       = (state_q == ST_OUT) ? err_q : 5'd0;
    o_frame_err = ferr_q;
    M_DATA      = 8'h00;
    if (state_q == ST_OUT) begin
      case (ocnt_q)
        5'd0:    M_DATA = hdr_q[23:16];
        5'd1:    M_DATA = hdr_q[15:8];
        5'd2:    M_DATA = hdr_q[7:0];
        default: M_DATA = pb_q[ocnt_q - 5'd3];
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ocnt_q  <= 5'd0;
      hdr_q   <= 24'd0;
      rhecc_q <= 8'd0;
      hecc_q  <= 8'd0;
      err_q   <= 5'd0;
      for (int k = 0; k < 4; k++) begin
        e_q[k] <= 8'd0;
        r_q[k] <= 8'd0;
      end
      for (int n = 0; n < 28; n++) pb_q[n] <= 8'd0;
    end else begin
      if (accept && (state_q == ST_RX)) begin
        if (cnt_q < 6'd24) begin
          hdr_q  <= {hdr_q[22:0], S_HDR};
          hecc_q <= hecc_nx;
        end else begin
          rhecc_q <= rhecc_fin;
        end
        if (cnt_q < 6'd28) begin
          pb_q[cnt_q[4:0]] <= S_DATA;
          for (int k = 0; k < 4; k++) e_q[k] <= e_nx[k];
        end else begin
          for (int k = 0; k < 4; k++) r_q[k] <= r_fin[k];
        end
        if (cnt_q == 6'd31) err_q <= err_nx;
      end
      if (out_hs) ocnt_q <= (ocnt_q == 5'd30) ? 5'd0 : ocnt_q + 5'd1;
    end
  end

endmodule

// File: tb/tb_hdmipktrx.sv
// Directed bench for hdmipktrx: a pass-through instance and a drop-bad instance share stimulus.
module tb_hdmipktrx;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       S_VALID = 1'b0, S_HDR = 1'b0, S_LAST = 1'b0, M_READY = 1'b0;
  logic [7:0] S_DATA = 8'h00;
  logic       sel = 1'b0;

  logic       sr0, mv0, ml0, fe0, sr1, mv1, ml1, fe1;
  logic [7:0] md0, md1;
  logic [4:0] me0, me1;
  logic       sv0, sv1;
  logic       sr, mv, ml, fe;
  logic [7:0] md;
  logic [4:0] me;

  int errors = 0;
  int checks = 0;
  int fcnt0 = 0, fcnt1 = 0, vcnt0 = 0, vcnt1 = 0;

  logic [7:0] hb_m [3];
  logic [7:0] pb_m [28];
  logic       w_hdr [32];
  logic [7:0] w_dat [32];
  logic [7:0] exp_b [31];

  always #5 i_clk = ~i_clk;

  assign sv0 = S_VALID && !sel;
  assign sv1 = S_VALID && sel;
  assign sr  = sel ? sr1 : sr0;
  assign mv  = sel ? mv1 : mv0;
  assign ml  = sel ? ml1 : ml0;
  assign md  = sel ? md1 : md0;
  assign me  = sel ? me1 : me0;
  assign fe  = sel ? fe1 : fe0;

  hdmipktrx #(.OPT_DROP_BAD(1'b0)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .S_VALID(sv0), .S_READY(sr0), .S_HDR(S_HDR), .S_DATA(S_DATA), .S_LAST(S_LAST),
    .M_VALID(mv0), .M_READY(M_READY), .M_DATA(md0), .M_LAST(ml0), .M_ERR(me0),
    .o_frame_err(fe0)
  );

  hdmipktrx #(.OPT_DROP_BAD(1'b1)) dut_drop (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .S_VALID(sv1), .S_READY(sr1), .S_HDR(S_HDR), .S_DATA(S_DATA), .S_LAST(S_LAST),
    .M_VALID(mv1), .M_READY(M_READY), .M_DATA(md1), .M_LAST(ml1), .M_ERR(me1),
    .o_frame_err(fe1)
  );

  always @(posedge i_clk) begin
    if (fe0) fcnt0++;
    if (fe1) fcnt1++;
    if (mv0) vcnt0++;
    if (mv1) vcnt1++;
  end

  function automatic logic [7:0] f_step(input logic [7:0] f, input logic b);
    f_step = (b ^ f[7]) ? ({f[6:0], 1'b0} ^ 8'hC1) : {f[6:0], 1'b0};
  endfunction

  task automatic set_pkt(input bit zero);
    hb_m[0] = zero ? 8'h00 : 8'h84;
    hb_m[1] = zero ? 8'h00 : 8'h02;
    hb_m[2] = zero ? 8'h00 : 8'h0D;
    for (int n = 0; n < 28; n++) pb_m[n] = zero ? 8'h00 : 8'(n);
  endtask

  // Wire-level encode of hb_m/pb_m with optional single-bit corruptions after the ECC is formed.
  task automatic encode(input int flip_hdr_beat, input int flip_pb, input logic [7:0] flip_mask);
    logic [7:0] h;
    logic [7:0] e [4];
    logic       b;
    h = 8'h00;
    for (int k = 0; k < 4; k++) e[k] = 8'h00;
    for (int i = 0; i < 24; i++) begin
      b = hb_m[i/8][7-(i%8)];
      h = f_step(h, b);
      w_hdr[i] = b;
    end
    for (int i = 0; i < 8; i++) w_hdr[24+i] = h[7-i];
    for (int i = 0; i < 28; i++) begin
      w_dat[i] = pb_m[i];
      for (int k = 0; k < 4; k++) e[k] = f_step(f_step(e[k], pb_m[i][k]), pb_m[i][k+4]);
    end
    for (int j = 0; j < 4; j++) begin
      w_dat[28+j] = 8'h00;
      for (int k = 0; k < 4; k++) begin
        w_dat[28+j][k]   = e[k][7-2*j];
        w_dat[28+j][k+4] = e[k][6-2*j];
      end
    end
    if (flip_hdr_beat >= 0) w_hdr[flip_hdr_beat] = ~w_hdr[flip_hdr_beat];
    if (flip_pb >= 0) w_dat[flip_pb] = w_dat[flip_pb] ^ flip_mask;
    for (int i = 0; i < 3; i++) exp_b[i] = 8'h00;
    for (int i = 0; i < 24; i++) exp_b[i/8][7-(i%8)] = w_hdr[i];
    for (int i = 0; i < 28; i++) exp_b[3+i] = w_dat[i];
  endtask

  task automatic send(input int n, input int last_at, input bit gaps);
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        @(negedge i_clk);
        S_VALID = 1'b0;
      end
      @(negedge i_clk);
      S_VALID = 1'b1;
      S_HDR   = w_hdr[i%32];
      S_DATA  = w_dat[i%32];
      S_LAST  = (i == last_at);
      t = 0;
      while (!sr && t < 100) begin
        @(negedge i_clk);
        t++;
      end
      checks++;
      if (t >= 100) begin
        errors++;
        $display("FAIL send_ready beat %0d: S_READY stayed %b, required 1", i, sr);
      end
    end
    @(negedge i_clk);
    S_VALID = 1'b0;
    S_LAST  = 1'b0;
  endtask

  // Called at a negedge; drains one packet and leaves the bench at the negedge after M_LAST.
  task automatic collect(input string name, input bit bp, input logic [4:0] experr);
    int idx, cyc;
    logic stalled, rdy, sl;
    logic [7:0] sd;
    logic [4:0] se;
    idx = 0; cyc = 0; stalled = 1'b0; sd = 8'h00; se = 5'd0; sl = 1'b0;
    while (idx < 31 && cyc < 400) begin
      if (stalled) begin
        checks++;
        if (!mv || md !== sd || me !== se || ml !== sl) begin
          errors++;
          $display("FAIL %s hold byte %0d: got v=%b d=%h e=%h l=%b, required v=1 d=%h e=%h l=%b",
                   name, idx, mv, md, me, ml, sd, se, sl);
        end
      end
      rdy = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      M_READY = rdy;
      stalled = 1'b0;
      if (mv) begin
        if (rdy) begin
          checks++;
          if (md !== exp_b[idx] || me !== experr || ml !== (idx == 30)) begin
            errors++;
            $display("FAIL %s byte %0d: got d=%h err=%h last=%b, required d=%h err=%h last=%b",
                     name, idx, md, me, ml, exp_b[idx], experr, (idx == 30));
          end
          idx++;
        end else begin
          stalled = 1'b1; sd = md; se = me; sl = ml;
        end
      end
      @(negedge i_clk);
      cyc++;
    end
    M_READY = 1'b0;
    checks++;
    if (idx < 31) begin
      errors++;
      $display("FAIL %s timeout: got %0d bytes, required 31", name, idx);
    end
    checks++;
    if (mv !== 1'b0 || sr !== 1'b1) begin
      errors++;
      $display("FAIL %s after_last: got M_VALID=%b S_READY=%b, required 0 1", name, mv, sr);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (sr0 !== 1'b1 || mv0 !== 1'b0 || md0 !== 8'h00 || ml0 !== 1'b0 || me0 !== 5'h00 || fe0 !== 1'b0) begin
      errors++;
      $display("FAIL reset: got rdy=%b v=%b d=%h l=%b e=%h fe=%b, required 1 0 00 0 00 0",
               sr0, mv0, md0, ml0, me0, fe0);
    end
  endtask

  task automatic test_zero;
    sel = 1'b0;
    set_pkt(1'b1);
    encode(-1, -1, 8'h00);
    send(32, 31, 1'b0);
    checks++;
    if (mv !== 1'b1 || sr !== 1'b0) begin
      errors++;
      $display("FAIL zero_latency: got M_VALID=%b S_READY=%b, required 1 0", mv, sr);
    end
    collect("zero", 1'b0, 5'h00);
  endtask

  task automatic test_good;
    sel = 1'b0;
    set_pkt(1'b0);
    encode(-1, -1, 8'h00);
    send(32, 31, 1'b0);
    collect("good", 1'b0, 5'h00);
  endtask

  task automatic test_backpressure;
    sel = 1'b0;
    set_pkt(1'b0);
    encode(-1, -1, 8'h00);
    send(32, 31, 1'b1);
    collect("backpressure", 1'b1, 5'h00);
  endtask

  task automatic test_ecc_err;
    sel = 1'b0;
    set_pkt(1'b0);
    encode(15, -1, 8'h00);
    checks++;
    if (exp_b[1] !== 8'h03) begin
      errors++;
      $display("FAIL hdr_flip_model: got HB1=%h, required 03", exp_b[1]);
    end
    send(32, 31, 1'b0);
    collect("hdr_err", 1'b0, 5'h10);
    encode(-1, 5, 8'h04);
    send(32, 31, 1'b0);
    collect("pb_err", 1'b0, 5'h04);
  endtask

  task automatic test_drop_bad;
    int vc;
    sel = 1'b1;
    set_pkt(1'b0);
    vc = vcnt1;
    encode(15, -1, 8'h00);
    send(32, 31, 1'b0);
    repeat (3) @(negedge i_clk);
    encode(-1, 5, 8'h04);
    send(32, 31, 1'b0);
    repeat (3) @(negedge i_clk);
    checks++;
    if (vcnt1 !== vc || sr1 !== 1'b1) begin
      errors++;
      $display("FAIL drop_bad: got %0d valid cycles rdy=%b, required 0 valid cycles rdy=1", vcnt1 - vc, sr1);
    end
    encode(-1, -1, 8'h00);
    send(32, 31, 1'b0);
    collect("drop_good", 1'b0, 5'h00);
    sel = 1'b0;
  endtask

  task automatic test_frame_short;
    int fc, vc;
    sel = 1'b0;
    set_pkt(1'b0);
    encode(-1, -1, 8'h00);
    fc = fcnt0; vc = vcnt0;
    send(21, 20, 1'b0);
    checks++;
    if (fe0 !== 1'b1) begin
      errors++;
      $display("FAIL short_pulse: got o_frame_err=%b, required 1", fe0);
    end
    @(negedge i_clk);
    checks++;
    if (fe0 !== 1'b0 || fcnt0 - fc != 1 || vcnt0 !== vc) begin
      errors++;
      $display("FAIL short_once: got fe=%b pulses=%0d valid=%0d, required 0 1 0", fe0, fcnt0 - fc, vcnt0 - vc);
    end
    send(32, 31, 1'b0);
    collect("after_short", 1'b0, 5'h00);
  endtask

  task automatic test_sync;
    int fc, vc;
    sel = 1'b0;
    set_pkt(1'b0);
    encode(-1, -1, 8'h00);
    fc = fcnt0; vc = vcnt0;
    send(40, -1, 1'b0);
    send(1, 0, 1'b0);
    repeat (2) @(negedge i_clk);
    checks++;
    if (fcnt0 - fc != 1 || vcnt0 !== vc) begin
      errors++;
      $display("FAIL sync: got pulses=%0d valid=%0d, required 1 0", fcnt0 - fc, vcnt0 - vc);
    end
    send(32, 31, 1'b0);
    collect("after_sync", 1'b0, 5'h00);
  endtask

  task automatic test_reset_mid;
    sel = 1'b0;
    set_pkt(1'b0);
    encode(-1, -1, 8'h00);
    send(32, 31, 1'b0);
    M_READY = 1'b1;
    repeat (10) @(negedge i_clk);
    checks++;
    if (mv0 !== 1'b1 || md0 !== 8'h07) begin
      errors++;
      $display("FAIL mid_byte10: got v=%b d=%h, required 1 07", mv0, md0);
    end
    i_reset_n = 1'b0;
    #1;
    checks++;
    if (mv0 !== 1'b0 || md0 !== 8'h00 || sr0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got v=%b d=%h rdy=%b, required 0 00 1", mv0, md0, sr0);
    end
    M_READY = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    send(32, 31, 1'b0);
    collect("after_reset", 1'b0, 5'h00);
  endtask

  initial begin
    i_reset_n = 1'b0;
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    test_reset();
    test_zero();
    test_good();
    test_backpressure();
    test_ecc_err();
    test_drop_bad();
    test_frame_short();
    test_sync();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
